datapath_config_regs: RTL and testbench

Parametrised AXI4-Lite slave register file that supersedes the fixed two-register datapath configuration block. It holds NUM_REGS read/write configuration words (exported as a flat bus plus per-register write pulses) and NUM_STAT read-only status words sampled from the datapath. It sits between the AXI interconnect and the packet datapath, and adds byte strobes, error responses and decoupled AW/W acceptance.

---
 rtl/datapath_config_regs.sv | 179 +++++++++++++++++
 tb/tb_datapath_config_regs.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_config_regs.sv
// rtl/datapath_config_regs.sv - AXI4-Lite config/status register file with byte strobes and error responses
module datapath_config_regs #(
    parameter int DW       = 32,
    parameter int AW       = 64,
    parameter int NUM_REGS = 8,
    parameter int NUM_STAT = 2,
    parameter logic [NUM_REGS*DW-1:0] RESET_VALUES = '0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    output logic [NUM_REGS*DW-1:0]                 CFG_REGS,
    output logic [NUM_REGS-1:0]                    CFG_WR_PULSE,
    input  logic [((NUM_STAT > 0) ? NUM_STAT : 1)*DW-1:0] STATUS_IN,
    input  logic [AW-1:0]                          CFG_AXI_AWADDR,
    input  logic                                   CFG_AXI_AWVALID,
    output logic                                   CFG_AXI_AWREADY,
    input  logic [DW-1:0]                          CFG_AXI_WDATA,
    input  logic [DW/8-1:0]                        CFG_AXI_WSTRB,
    input  logic                                   CFG_AXI_WVALID,
    output logic                                   CFG_AXI_WREADY,
    output logic [1:0]                             CFG_AXI_BRESP,
    output logic                                   CFG_AXI_BVALID,
    input  logic                                   CFG_AXI_BREADY,
    input  logic [AW-1:0]                          CFG_AXI_ARADDR,
    input  logic                                   CFG_AXI_ARVALID,
    output logic                                   CFG_AXI_ARREADY,
    output logic [DW-1:0]                          CFG_AXI_RDATA,
    output logic [1:0]                             CFG_AXI_RRESP,
    output logic                                   CFG_AXI_RVALID,
    input  logic                                   CFG_AXI_RREADY
);

    localparam int SB   = DW / 8;
    localparam int OFFS = $clog2(SB);

    localparam logic [2:0] WR_IDLE    = 3'd0;
    localparam logic [2:0] WR_HAVE_AW = 3'd1;
    localparam logic [2:0] WR_HAVE_W  = 3'd2;
    localparam logic [2:0] WR_COMMIT  = 3'd3;
    localparam logic [2:0] WR_RESP    = 3'd4;
    localparam logic [0:0] RD_IDLE    = 1'b0;
    localparam logic [0:0] RD_RESP    = 1'b1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                         ready_en_q;
    logic [2:0]                   wr_state_q, wr_state_d;
    logic [AW-1:0]                aw_addr_q, aw_addr_d;
    logic [DW-1:0]                wdata_q, wdata_d;
    logic [SB-1:0]                wstrb_q, wstrb_d;
    logic [NUM_REGS-1:0][DW-1:0]  cfg_q, cfg_d;
    logic [NUM_REGS-1:0]          pulse_q, pulse_d;
    logic [1:0]                   bresp_q, bresp_d;
    logic [0:0]                   rd_state_q, rd_state_d;
    logic [DW-1:0]                rdata_q, rdata_d;
    logic [1:0]                   rresp_q, rresp_d;

    logic          aw_hs, w_hs, ar_hs;
    logic [AW-1:0] aw_idx, ar_idx;
    logic          unused_status;

    // Stays low through reset so no channel looks ready before the first post-reset edge.
    assign CFG_AXI_AWREADY = ready_en_q && (wr_state_q == WR_IDLE || wr_state_q == WR_HAVE_W);
    assign CFG_AXI_WREADY  = ready_en_q && (wr_state_q == WR_IDLE || wr_state_q == WR_HAVE_AW);
    assign CFG_AXI_ARREADY = ready_en_q && (rd_state_q == RD_IDLE);
    assign CFG_AXI_BVALID  = (wr_state_q == WR_RESP);
    assign CFG_AXI_BRESP   = bresp_q;
    assign CFG_AXI_RVALID  = (rd_state_q == RD_RESP);
    assign CFG_AXI_RDATA   = rdata_q;
    assign CFG_AXI_RRESP   = rresp_q;
    assign CFG_REGS        = cfg_q;
    assign CFG_WR_PULSE    = pulse_q;
    assign unused_status   = ^STATUS_IN;

    assign aw_hs  = CFG_AXI_AWVALID && CFG_AXI_AWREADY;
    assign w_hs   = CFG_AXI_WVALID && CFG_AXI_WREADY;
    assign ar_hs  = CFG_AXI_ARVALID && CFG_AXI_ARREADY;
    assign aw_idx = aw_addr_q >> OFFS;
    assign ar_idx = CFG_AXI_ARADDR >> OFFS;

    always_comb begin
        wr_state_d = wr_state_q;
        aw_addr_d  = aw_addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        cfg_d      = cfg_q;
        pulse_d    = '0;
        bresp_d    = bresp_q;
        if (aw_hs) aw_addr_d = CFG_AXI_AWADDR;
        if (w_hs) begin
            wdata_d = CFG_AXI_WDATA;
            wstrb_d = CFG_AXI_WSTRB;
        end
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) wr_state_d = WR_COMMIT;
                else if (aw_hs)    wr_state_d = WR_HAVE_AW;
                else if (w_hs)     wr_state_d = WR_HAVE_W;
            end
            WR_HAVE_AW: if (w_hs) wr_state_d = WR_COMMIT;
            WR_HAVE_W:  if (aw_hs) wr_state_d = WR_COMMIT;
            WR_COMMIT: begin
                // Status and out-of-range targets fall through with SLVERR and no side effects.
                wr_state_d = WR_RESP;
                bresp_d    = RESP_SLVERR;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (aw_idx == AW'(i)) begin
                        bresp_d    = RESP_OKAY;
                        pulse_d[i] = 1'b1;
                        for (int b = 0; b < SB; b++) begin
                            if (wstrb_q[b]) cfg_d[i][b*8 +: 8] = wdata_q[b*8 +: 8];
                        end
                    end
                end
            end
            WR_RESP: if (CFG_AXI_BREADY) wr_state_d = WR_IDLE;
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // Reads sample cfg_q, so a same-cycle commit to the same register is not visible.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (ar_hs) begin
                    rd_state_d = RD_RESP;
                    rdata_d    = '0;
                    rresp_d    = RESP_SLVERR;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (ar_idx == AW'(i)) begin
                            rdata_d = cfg_q[i];
                            rresp_d = RESP_OKAY;
                        end
                    end
                    for (int j = 0; j < NUM_STAT; j++) begin
                        if (ar_idx == AW'(NUM_REGS + j)) begin
                            rdata_d = STATUS_IN[j*DW +: DW];
                            rresp_d = RESP_OKAY;
                        end
                    end
                end
            end
            RD_RESP: if (CFG_AXI_RREADY) rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_en_q <= 1'b0;
            wr_state_q <= WR_IDLE;
            aw_addr_q  <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            cfg_q      <= RESET_VALUES;
            pulse_q    <= '0;
            bresp_q    <= RESP_OKAY;
            rd_state_q <= RD_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            ready_en_q <= 1'b1;
            wr_state_q <= wr_state_d;
            aw_addr_q  <= aw_addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            cfg_q      <= cfg_d;
            pulse_q    <= pulse_d;
            bresp_q    <= bresp_d;
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

endmodule

// File: tb/tb_datapath_config_regs.sv
// tb/tb_datapath_config_regs.sv - directed self-checking bench for datapath_config_regs
module tb_datapath_config_regs;

    localparam int DW = 32;
    localparam int AW = 64;
    localparam int NR = 8;
    localparam int NS = 2;
    localparam logic [NR*DW-1:0] RV = (NR*DW)'(32'h0000_0400) << DW;

    logic              clk;
    logic              reset;
    logic [NR*DW-1:0]  cfg_regs;
    logic [NR-1:0]     wr_pulse;
    logic [NS*DW-1:0]  status_in;
    logic [AW-1:0]     awaddr, araddr;
    logic              awvalid, awready, wvalid, wready;
    logic [DW-1:0]     wdata, rdata;
    logic [DW/8-1:0]   wstrb;
    logic [1:0]        bresp, rresp;
    logic              bvalid, bready, arvalid, arready, rvalid, rready;

    int checks = 0;
    int errors = 0;

    datapath_config_regs #(
        .DW(DW), .AW(AW), .NUM_REGS(NR), .NUM_STAT(NS), .RESET_VALUES(RV)
    ) dut (
        .clk(clk), .reset(reset),
        .CFG_REGS(cfg_regs), .CFG_WR_PULSE(wr_pulse), .STATUS_IN(status_in),
        .CFG_AXI_AWADDR(awaddr), .CFG_AXI_AWVALID(awvalid), .CFG_AXI_AWREADY(awready),
        .CFG_AXI_WDATA(wdata), .CFG_AXI_WSTRB(wstrb), .CFG_AXI_WVALID(wvalid), .CFG_AXI_WREADY(wready),
        .CFG_AXI_BRESP(bresp), .CFG_AXI_BVALID(bvalid), .CFG_AXI_BREADY(bready),
        .CFG_AXI_ARADDR(araddr), .CFG_AXI_ARVALID(arvalid), .CFG_AXI_ARREADY(arready),
        .CFG_AXI_RDATA(rdata), .CFG_AXI_RRESP(rresp), .CFG_AXI_RVALID(rvalid), .CFG_AXI_RREADY(rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] reg_of(input int i);
        return cfg_regs[i*DW +: DW];
    endfunction

    task automatic axi_write(input logic [63:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [7:0] pulse);
        bit aw_ok, w_ok, aw_acc, w_acc;
        int n;
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        aw_ok = 0; w_ok = 0; n = 0;
        resp = 2'b11; pulse = '0;
        while (!(aw_ok && w_ok) && n < 20) begin
            aw_acc = awvalid && awready;
            w_acc  = wvalid && wready;
            tick();
            if (aw_acc) begin aw_ok = 1; awvalid = 1'b0; end
            if (w_acc)  begin w_ok = 1;  wvalid = 1'b0; end
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            tick();
            n++;
        end
        if (!bvalid) begin
            check("wr_timeout", 64'd0, 64'd1);
        end else begin
            resp = bresp;
            pulse = wr_pulse;
            bready = 1'b1;
            tick();
            bready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [63:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit acc, a;
        int n;
        araddr = addr; arvalid = 1'b1;
        acc = 0; n = 0;
        data = '0; resp = 2'b11;
        while (!acc && n < 20) begin
            a = arvalid && arready;
            tick();
            if (a) begin acc = 1; arvalid = 1'b0; end
            n++;
        end
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            tick();
            n++;
        end
        if (!rvalid) begin
            check("rd_timeout", 64'd0, 64'd1);
        end else begin
            data = rdata;
            resp = rresp;
            rready = 1'b1;
            tick();
            rready = 1'b0;
        end
    endtask

    initial begin
        logic [31:0]      d;
        logic [1:0]       r;
        logic [7:0]       p;
        logic [NR*DW-1:0] saved;

        reset = 1'b1;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;
        status_in = '0;
        repeat (3) tick();

        check("rst_awready", 64'(awready), 64'd0);
        check("rst_wready", 64'(wready), 64'd0);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_pulse", 64'(wr_pulse), 64'd0);
        check("rst_reg1", 64'(reg_of(1)), 64'h400);
        check("rst_reg0", 64'(reg_of(0)), 64'h0);

        reset = 1'b0;
        check("rel_awready_early", 64'(awready), 64'd0);
        tick();
        check("rel_awready", 64'(awready), 64'd1);
        check("rel_wready", 64'(wready), 64'd1);
        check("rel_arready", 64'(arready), 64'd1);

        axi_read(64'h4, d, r);
        check("rd_reg1_data", 64'(d), 64'h400);
        check("rd_reg1_resp", 64'(r), 64'd0);
        axi_read(64'h5, d, r);
        check("rd_offset_ignored", 64'(d), 64'h400);

        // W three cycles ahead of AW, then hold BVALID with BREADY low.
        wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        tick();
        check("wfirst_wready_low", 64'(wready), 64'd0);
        check("wfirst_awready_high", 64'(awready), 64'd1);
        tick();
        awaddr = 64'h8; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("wfirst_no_b_yet", 64'(bvalid), 64'd0);
        check("wfirst_no_pulse_yet", 64'(wr_pulse), 64'd0);
        tick();
        check("wfirst_bvalid", 64'(bvalid), 64'd1);
        check("wfirst_bresp", 64'(bresp), 64'd0);
        check("wfirst_pulse", 64'(wr_pulse), 64'h04);
        check("wfirst_reg2", 64'(reg_of(2)), 64'hDEAD_BEEF);
        awaddr = 64'hC; awvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bhold_bvalid", 64'(bvalid), 64'd1);
            check("bhold_awready", 64'(awready), 64'd0);
            check("bhold_pulse", 64'(wr_pulse), 64'd0);
        end
        awvalid = 1'b0;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("bdone_bvalid", 64'(bvalid), 64'd0);
        check("bdone_awready", 64'(awready), 64'd1);
        check("bdone_reg3", 64'(reg_of(3)), 64'h0);

        axi_write(64'h0, 32'h1122_3344, 4'hF, r, p);
        check("reg0_full", 64'(reg_of(0)), 64'h1122_3344);
        axi_write(64'h0, 32'hAABB_CCDD, 4'h5, r, p);
        check("reg0_strb", 64'(reg_of(0)), 64'h11BB_33DD);
        check("reg0_strb_resp", 64'(r), 64'd0);
        check("reg0_strb_pulse", 64'(p), 64'h01);

        saved = cfg_regs;
        axi_write(64'h20, 32'hFFFF_FFFF, 4'hF, r, p);
        check("stat_wr_resp", 64'(r), 64'h2);
        check("stat_wr_pulse", 64'(p), 64'h0);
        check("stat_wr_regs_same", 64'(cfg_regs == saved), 64'd1);
        axi_read(64'h28, d, r);
        check("oor_rd_data", 64'(d), 64'h0);
        check("oor_rd_resp", 64'(r), 64'h2);

        status_in = {32'h0000_1234, 32'h0000_0055};
        axi_read(64'h20, d, r);
        check("stat0_data", 64'(d), 64'h55);
        check("stat0_resp", 64'(r), 64'd0);
        axi_read(64'h24, d, r);
        check("stat1_data", 64'(d), 64'h1234);

        // AR handshake lands on the same edge as the reg3 commit.
        axi_write(64'hC, 32'h1, 4'hF, r, p);
        check("reg3_init", 64'(reg_of(3)), 64'h1);
        awaddr = 64'hC; awvalid = 1'b1; wdata = 32'h7; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 64'hC; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("race_rvalid", 64'(rvalid), 64'd1);
        check("race_rdata_old", 64'(rdata), 64'h1);
        check("race_reg3_new", 64'(reg_of(3)), 64'h7);
        check("race_pulse", 64'(wr_pulse), 64'h08);
        check("race_arready_low", 64'(arready), 64'd0);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        check("race_arready_back", 64'(arready), 64'd1);
        check("race_rvalid_done", 64'(rvalid), 64'd0);

        // Reset while both responses are pending.
        awaddr = 64'h8; awvalid = 1'b1; wdata = 32'h99; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 64'h0; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tick();
        check("pre_rst_bvalid", 64'(bvalid), 64'd1);
        check("pre_rst_rvalid", 64'(rvalid), 64'd1);
        check("pre_rst_reg2", 64'(reg_of(2)), 64'h99);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_bvalid", 64'(bvalid), 64'd0);
        check("mid_rst_rvalid", 64'(rvalid), 64'd0);
        check("mid_rst_reg2", 64'(reg_of(2)), 64'h0);
        check("mid_rst_reg1", 64'(reg_of(1)), 64'h400);
        check("mid_rst_reg0", 64'(reg_of(0)), 64'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        axi_write(64'h8, 32'h1234_5678, 4'hF, r, p);
        check("post_rst_resp", 64'(r), 64'd0);
        check("post_rst_pulse", 64'(p), 64'h04);
        check("post_rst_reg2", 64'(reg_of(2)), 64'h1234_5678);
        axi_read(64'h8, d, r);
        check("post_rst_rd", 64'(d), 64'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
